// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register offsets,
// CLAIM response layout and the largest supported source count.
package irq_pkg;

    localparam logic [2:0] REG_RAW      = 3'd0;
    localparam logic [2:0] REG_PENDING  = 3'd1;
    localparam logic [2:0] REG_ENABLE   = 3'd2;
    localparam logic [2:0] REG_EDGE     = 3'd3;
    localparam logic [2:0] REG_CLAIM    = 3'd4;
    localparam logic [2:0] REG_COMPLETE = 3'd5;

    localparam int CLAIM_VALID_BIT = 31;
    localparam int MAX_SRC         = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest-numbered eligible source wins.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NSRC = MAX_SRC
) (
    input  logic [NSRC-1:0] eligible,
    output logic            valid,
    output logic [2:0]      id
);

    // Scanning downwards lets the lowest set index overwrite any higher one.
    always_comb begin
        valid = 1'b0;
        id    = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                valid = 1'b1;
                id    = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller with level/edge sources, enable mask,
// fixed-priority claim/complete handshake and a registered CPU interrupt.
module irq_controller
    import irq_pkg::*;
#(
    parameter int         NSRC       = 8,
    parameter logic [7:0] RESET_EDGE = 8'h00
) (
    input  logic            clk,
    input  logic            resetq,
    input  logic            select,
    input  logic [3:0]      we,
    input  logic            rd,
    input  logic [2:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [NSRC-1:0] src,
    output logic            irq
);

    localparam logic [NSRC-1:0] ONE = NSRC'(1);

    logic [1:0]      rst_sync;
    logic            rst_n;
    logic            wr;
    logic            rd_en;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] edge_mode;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] pending_next;
    logic [NSRC-1:0] inservice;
    logic [NSRC-1:0] prev_src;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] claim_set;
    logic [NSRC-1:0] done_clr;
    logic [NSRC-1:0] edge_chg;
    logic            claim_valid;
    logic [2:0]      claim_id;
    logic [31:0]     read_val;
    logic            unused;

    assign unused = &{1'b0, we[3:1], wdata[31:NSRC]};

    // Reset asserts immediately but is released two clock edges later.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    assign wr       = select & we[0];
    assign rd_en    = select & rd;
    assign eligible = pending & enable & ~inservice;

    irq_prio_enc #(
        .NSRC (NSRC)
    ) u_prio_enc (
        .eligible (eligible),
        .valid    (claim_valid),
        .id       (claim_id)
    );

    assign rise      = edge_mode & src & ~prev_src;
    assign w1c       = (wr && addr == REG_PENDING) ? wdata[NSRC-1:0] : '0;
    assign claim_set = (rd_en && addr == REG_CLAIM && claim_valid) ? (ONE << claim_id) : '0;
    assign done_clr  = (wr && addr == REG_COMPLETE) ? (ONE << wdata[2:0]) : '0;
    assign edge_chg  = (wr && addr == REG_EDGE) ? (wdata[NSRC-1:0] ^ edge_mode) : '0;

    // Edge bits: a new rising edge beats a same-cycle clear. Level bits track src.
    // Bits whose mode is being changed start again from a clean pending state.
    assign pending_next = ((edge_mode & (rise | (pending & ~(w1c | claim_set))))
                          | (~edge_mode & src)) & ~edge_chg;

    always_comb begin
        read_val = '0;
        case (addr)
            REG_RAW:     read_val = 32'(src);
            REG_PENDING: read_val = 32'(pending);
            REG_ENABLE:  read_val = 32'(enable);
            REG_EDGE:    read_val = 32'(edge_mode);
            REG_CLAIM: begin
                if (claim_valid) begin
                    read_val[CLAIM_VALID_BIT] = 1'b1;
                    read_val[2:0]             = claim_id;
                end
            end
            default: read_val = '0;
        endcase
    end

    // prev_src follows src every cycle, so a mode change also resyncs it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable    <= '0;
            edge_mode <= RESET_EDGE[NSRC-1:0];
            pending   <= '0;
            inservice <= '0;
            prev_src  <= '0;
            rdata     <= '0;
            irq       <= 1'b0;
        end else begin
            prev_src  <= src;
            pending   <= pending_next;
            inservice <= (inservice | claim_set) & ~done_clr;
            irq       <= |eligible;
            if (wr && addr == REG_ENABLE) begin
                enable <= wdata[NSRC-1:0];
            end
            if (wr && addr == REG_EDGE) begin
                edge_mode <= wdata[NSRC-1:0];
            end
            if (rd_en) begin
                rdata <= read_val;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase compared every cycle against a behavioural model.
module tb_irq_controller;
    import irq_pkg::*;

    logic        clk    = 1'b0;
    logic        resetq = 1'b1;
    logic        sel    = 1'b0;
    logic        use4   = 1'b0;
    logic        rd     = 1'b0;
    logic [3:0]  we     = 4'h0;
    logic [2:0]  addr   = 3'd0;
    logic [31:0] wdata  = 32'h0;
    logic [7:0]  src    = 8'h0;
    logic [3:0]  src4   = 4'h0;
    logic [31:0] rdata;
    logic [31:0] rdata4;
    logic        irq;
    logic        irq4;
    logic        sel8;
    logic        sel4;
    logic [31:0] d;

    int n_checks = 0;
    int n_pass   = 0;

    assign sel8 = sel & ~use4;
    assign sel4 = sel & use4;

    always #5 clk = ~clk;

    irq_controller #(.NSRC(8), .RESET_EDGE(8'h00)) dut (
        .clk(clk), .resetq(resetq), .select(sel8), .we(we), .rd(rd), .addr(addr),
        .wdata(wdata), .rdata(rdata), .src(src), .irq(irq)
    );

    irq_controller #(.NSRC(4), .RESET_EDGE(8'h00)) dut4 (
        .clk(clk), .resetq(resetq), .select(sel4), .we(we), .rd(rd), .addr(addr),
        .wdata(wdata), .rdata(rdata4), .src(src4), .irq(irq4)
    );

    // Behavioural model of the 8-source instance.
    logic [7:0]  m_enable  = 8'h0;
    logic [7:0]  m_edge    = 8'h0;
    logic [7:0]  m_pending = 8'h0;
    logic [7:0]  m_insvc   = 8'h0;
    logic [7:0]  m_prev    = 8'h0;
    logic [31:0] m_rdata   = 32'h0;
    logic        m_irq     = 1'b0;
    int          m_hold    = 2;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        logic [7:0]  np;
        logic [7:0]  ni;
        logic [7:0]  nen;
        logic [7:0]  nedge;
        logic [31:0] nr;
        logic        wr_s;
        logic        rd_s;
        logic        clear;
        int          win;
        wr_s  = sel8 && we[0];
        rd_s  = sel8 && rd;
        np    = m_pending;
        ni    = m_insvc;
        nen   = m_enable;
        nedge = m_edge;
        nr    = m_rdata;
        win   = -1;
        for (int i = 0; i < 8; i++)
            if (win < 0 && m_pending[i] && m_enable[i] && !m_insvc[i]) win = i;
        for (int i = 0; i < 8; i++) begin
            if (m_edge[i]) begin
                clear = (wr_s && addr == REG_PENDING && wdata[i]) ||
                        (rd_s && addr == REG_CLAIM && win == i);
                if (src[i] && !m_prev[i]) np[i] = 1'b1;
                else if (clear) np[i] = 1'b0;
            end else begin
                np[i] = src[i];
            end
        end
        if (rd_s) begin
            case (addr)
                REG_RAW:     nr = {24'h0, src};
                REG_PENDING: nr = {24'h0, m_pending};
                REG_ENABLE:  nr = {24'h0, m_enable};
                REG_EDGE:    nr = {24'h0, m_edge};
                REG_CLAIM:   nr = (win >= 0) ? (32'h8000_0000 | 32'(win)) : 32'h0;
                default:     nr = 32'h0;
            endcase
            if (addr == REG_CLAIM && win >= 0) ni[win] = 1'b1;
        end
        if (wr_s) begin
            case (addr)
                REG_ENABLE:   nen = wdata[7:0];
                REG_EDGE: begin
                    nedge = wdata[7:0];
                    for (int i = 0; i < 8; i++)
                        if (wdata[i] != m_edge[i]) np[i] = 1'b0;
                end
                REG_COMPLETE: ni[wdata[2:0]] = 1'b0;
                default: ;
            endcase
        end
        m_irq     = (win >= 0);
        m_prev    = src;
        m_pending = np;
        m_insvc   = ni;
        m_enable  = nen;
        m_edge    = nedge;
        m_rdata   = nr;
    endtask

    initial forever begin
        @(posedge clk or negedge resetq);
        if (!resetq) begin
            m_enable  = 8'h0;
            m_edge    = 8'h0;
            m_pending = 8'h0;
            m_insvc   = 8'h0;
            m_prev    = 8'h0;
            m_rdata   = 32'h0;
            m_irq     = 1'b0;
            m_hold    = 2;
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            model_step();
        end
    end

    initial begin
        @(negedge resetq);
        forever begin
            @(posedge clk);
            #1;
            check_output("model_rdata", rdata, m_rdata);
            check_output("model_irq", {31'h0, irq}, {31'h0, m_irq});
        end
    end

    // Bus tasks are entered just after a falling edge and return at the next one.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] dat, input logic [3:0] mask = 4'h1);
        sel = 1'b1; we = mask; addr = a; wdata = dat;
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0; we = 4'h0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] dat);
        sel = 1'b1; rd = 1'b1; addr = a;
        @(posedge clk);
        @(negedge clk);
        sel = 1'b0; rd = 1'b0;
        dat = use4 ? rdata4 : rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus();
        // Level source claim/complete cycle
        bus_write(REG_ENABLE, 32'h01);
        src = 8'h01;
        @(negedge clk);
        check_output("level_irq_1cyc", {31'h0, irq}, 32'h0);
        @(negedge clk);
        check_output("level_irq_2cyc", {31'h0, irq}, 32'h1);
        bus_read(REG_CLAIM, d);
        check_output("level_claim", d, 32'h8000_0000);
        @(negedge clk);
        check_output("level_irq_drop", {31'h0, irq}, 32'h0);
        bus_write(REG_COMPLETE, 32'h0);
        @(negedge clk);
        check_output("level_irq_again", {31'h0, irq}, 32'h1);
        src = 8'h00;
        bus_write(REG_ENABLE, 32'h0);
        idle(2);

        // Edge latch
        bus_write(REG_EDGE, 32'h02);
        bus_write(REG_ENABLE, 32'h02);
        src = 8'h02;
        @(negedge clk);
        src = 8'h00;
        @(negedge clk);
        bus_read(REG_PENDING, d);
        check_output("edge_pending", d, 32'h02);
        bus_read(REG_CLAIM, d);
        check_output("edge_claim", d, 32'h8000_0001);
        bus_read(REG_PENDING, d);
        check_output("edge_pending_clr", d, 32'h00);
        bus_write(REG_COMPLETE, 32'h1);
        bus_write(REG_ENABLE, 32'h0);
        bus_write(REG_EDGE, 32'h0);

        // Priority between sources 2 and 5
        bus_write(REG_ENABLE, 32'h24);
        src = 8'h24;
        idle(2);
        bus_read(REG_CLAIM, d);
        check_output("prio_first", d, 32'h8000_0002);
        bus_read(REG_CLAIM, d);
        check_output("prio_second", d, 32'h8000_0005);
        bus_read(REG_CLAIM, d);
        check_output("prio_third", d, 32'h0);
        idle(2);
        check_output("prio_irq_low", {31'h0, irq}, 32'h0);
        bus_write(REG_COMPLETE, 32'h2);
        @(negedge clk);
        check_output("prio_irq_back", {31'h0, irq}, 32'h1);
        bus_write(REG_COMPLETE, 32'h5);
        src = 8'h00;
        bus_write(REG_ENABLE, 32'h0);
        idle(2);

        // Rising edge collides with W1C of the same bit
        bus_write(REG_EDGE, 32'h08);
        idle(1);
        src = 8'h08;
        bus_write(REG_PENDING, 32'h08);
        bus_read(REG_PENDING, d);
        check_output("collide_set_wins", d, 32'h08);
        bus_write(REG_PENDING, 32'h08);
        bus_read(REG_PENDING, d);
        check_output("w1c_clears", d, 32'h00);
        src = 8'h00;
        bus_write(REG_EDGE, 32'h0);

        // Nothing eligible: CLAIM returns 0
        bus_read(REG_CLAIM, d);
        check_output("claim_empty", d, 32'h0);

        // Out-of-range COMPLETE on the 4-source instance
        use4 = 1'b1;
        bus_write(REG_ENABLE, 32'h1);
        src4 = 4'h1;
        idle(2);
        bus_read(REG_CLAIM, d);
        check_output("n4_claim", d, 32'h8000_0000);
        bus_write(REG_COMPLETE, 32'h7);
        bus_read(REG_CLAIM, d);
        check_output("n4_claim_none", d, 32'h0);
        idle(1);
        check_output("n4_irq_held", {31'h0, irq4}, 32'h0);
        bus_write(REG_COMPLETE, 32'h0);
        @(negedge clk);
        check_output("n4_irq_back", {31'h0, irq4}, 32'h1);
        src4 = 4'h0;
        use4 = 1'b0;

        // Reset between claim and complete
        bus_write(REG_ENABLE, 32'h01);
        src = 8'h01;
        idle(2);
        bus_read(REG_CLAIM, d);
        check_output("rst_claim", d, 32'h8000_0000);
        resetq = 1'b0;
        #1;
        check_output("rst_irq", {31'h0, irq}, 32'h0);
        check_output("rst_rdata", rdata, 32'h0);
        idle(2);
        resetq = 1'b1;
        idle(2);
        bus_read(REG_ENABLE, d);
        check_output("rst_enable", d, 32'h0);
        bus_read(REG_EDGE, d);
        check_output("rst_edge", d, 32'h0);
        bus_write(REG_ENABLE, 32'h01);
        @(negedge clk);
        check_output("rst_irq_reraise", {31'h0, irq}, 32'h1);
        src = 8'h00;
        bus_write(REG_ENABLE, 32'h0);
        idle(2);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) src = 8'($urandom);
            if ($urandom_range(299) == 0) begin
                resetq = 1'b0;
                idle(2);
                resetq = 1'b1;
                idle(1);
            end else begin
                case ($urandom_range(9))
                    0, 1, 2: idle(1);
                    3: bus_write(3'($urandom_range(7)), $urandom, 4'($urandom));
                    4: bus_write(REG_ENABLE, $urandom);
                    5: bus_write(REG_COMPLETE, 32'($urandom_range(7)));
                    6: bus_write(REG_PENDING, $urandom);
                    7: bus_read(3'($urandom_range(7)), d);
                    default: bus_read(REG_CLAIM, d);
                endcase
            end
        end
    endtask

    initial begin
        #3 resetq = 1'b0;
        idle(2);
        resetq = 1'b1;
        idle(3);
        apply_stimulus();
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL have parameter NSRC, default 8, meaning number of interrupt sources (1..8).
REQ-002 SHALL have parameter RESET_EDGE, default 8'h00, meaning EDGE register value after reset.
REQ-003 SHALL have port clk, input, 1 bit, the system clock; this is the only clock.
REQ-004 SHALL have port resetq, input, 1 bit, the reset: asynchronous assertion, active-low.
REQ-005 SHALL have port select, input, 1 bit, the decoded peripheral select.
REQ-006 SHALL have port we, input, 4 bits, CPU write byte mask; only we[0] is significant.
REQ-007 SHALL have port rd, input, 1 bit, CPU read strobe.
REQ-008 SHALL have port addr, input, 3 bits, word address (mem_addr[4:2]).
REQ-009 SHALL have port wdata, input, 32 bits, CPU write data.
REQ-010 SHALL have port rdata, output, 32 bits, registered read data.
REQ-011 SHALL have port src, input, NSRC bits, interrupt sources, synchronous to clk.
REQ-012 SHALL have port irq, output, 1 bit, registered CPU interrupt request.

Function
REQ-013 SHALL decode the register map by addr:
- 0 RAW (R): src.
- 1 PENDING (R/W1C).
- 2 ENABLE (RW).
- 3 EDGE (RW): 1 = rising-edge latched, 0 = level.
- 4 CLAIM (R, side effect).
- 5 COMPLETE (W).
- 6, 7: read 0, writes ignored.
REQ-014 SHALL perform a write only when select & we[0], using wdata[NSRC-1:0]; unused upper bits SHALL read 0.
REQ-015 SHALL load rdata on the clock edge where select & rd, and hold it otherwise, so data is valid the cycle after rd.
REQ-016 Level source i: pending[i] SHALL equal src[i] each cycle; W1C SHALL have no effect on it.
REQ-017 Edge source i: pending[i] SHALL set the cycle after src[i] goes 0->1 against its registered previous value, and hold until cleared by W1C or claim.
REQ-018 An edge-set event and a W1C or claim on the same bit in the same cycle SHALL resolve as set wins.
REQ-019 SHALL define eligible = pending & enable & ~inservice, with an NSRC-bit in-service register.
REQ-020 SHALL drive irq = |eligible, registered, i.e. 1 cycle after eligible changes.
REQ-021 SHALL grant fixed priority: lowest index highest.
REQ-022 A CLAIM read with eligible != 0 SHALL return {1'b1 at bit31, 28'b0, id[2:0]} for the winning source.
REQ-023 The same CLAIM read SHALL, in the same cycle, set inservice[id] and clear pending[id] if source id is edge mode.
REQ-024 A CLAIM read with eligible == 0 SHALL return 0 and change no state.
REQ-025 A COMPLETE write with wdata[2:0]=id SHALL clear inservice[id]; an id not in service or id >= NSRC SHALL be ignored.
REQ-026 A claim and a complete in the same cycle are impossible (one bus operation per cycle); no arbitration between them is required.
REQ-027 A change of the EDGE register SHALL clear pending for the changed bits and resync their previous-value registers.
REQ-028 Clearing enable[i] SHALL NOT clear pending[i] or inservice[i].

Reset
REQ-029 While resetq is low, the block SHALL hold: ENABLE=0, EDGE=RESET_EDGE, pending=0, inservice=0, previous-src=0, rdata=0, irq=0.
REQ-030 Reset SHALL take effect immediately (asynchronous assertion) and be released synchronously to clk.
REQ-031 Reset asserted mid-claim SHALL discard the claim; no source SHALL remain in service after release.

Structure
REQ-032 Package irq_pkg SHALL hold the register offset constants (RAW..COMPLETE), the CLAIM valid-bit position, and the maximum source count.
REQ-033 The fixed-priority encoder SHALL be a sub-module irq_prio_enc, with inputs eligible[NSRC] and outputs valid and id[2:0].
REQ-034 Total RTL SHALL fit within 120-400 lines.

Verification
REQ-035 Level source: ENABLE=0x01, src[0]=1 -> irq=1 after 2 cycles; CLAIM reads 0x80000000; irq drops the next cycle; COMPLETE 0 with src[0] still 1 -> irq=1 again.
REQ-036 Edge latch: EDGE=0x02, ENABLE=0x02, 1-cycle pulse on src[1] -> PENDING reads 0x02; CLAIM reads 0x80000001, then PENDING reads 0x00.
REQ-037 Priority: src[5] and src[2] both pending and enabled -> first CLAIM returns id 2, second returns id 5, third returns 0; irq=0 until a COMPLETE.
REQ-038 Collision: W1C of bit 3 in the same cycle as a rising edge on edge-mode src[3] -> pending[3] stays 1.
REQ-039 Boundaries: COMPLETE id 7 with NSRC=4 -> no state change; CLAIM with nothing eligible -> 0 and no side effects.
REQ-040 Reset: assert resetq=0 between a CLAIM and its COMPLETE -> irq=0 and all registers at reset values; after release, a still-high level source re-raises irq.
